fp_add_seq: RTL

Multi-cycle IEEE-754 single-precision adder/subtractor with valid/ready handshakes on both sides. It is the registered, flow-controlled counterpart of the combinational floating-point subtraction datapath, and performs a = a + b or a = a - b.
It is used wherever FP results must cross pipeline or handshake boundaries. Each operation takes a fixed latency and is processed by a single-issue FSM.

---
 rtl/fp_add_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
// Computes float1 + float2 (op=0) or float1 - float2 (op=1) through the
// fixed sequence IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE.
// Rounding is round-to-nearest-even. Denormal inputs are treated as zero,
// and tiny results are flushed to zero.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   float1, float2, op    operands and operation, captured on accept
//   out_valid / out_ready result handshake (result held until accepted)
//   result                IEEE-754 single result
//   flags                 {invalid, overflow, underflow}, valid with out_valid
module fp_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float1,
    input  logic [31:0] float2,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;

    // Captured operands; opb already carries the op-adjusted sign.
    logic [31:0] opa, opb;

    // Special-case result resolved in ALIGN and carried unchanged to ROUND.
    logic        sp;
    logic [31:0] sp_result;
    logic [2:0]  sp_flags;

    // Datapath registers between stages.
    logic               sign_big, eff_sub;
    logic [7:0]         exp_big;
    logic [26:0]        mant_big, mant_small;   // {mant[23:0], G, R, S}
    logic [27:0]        sum;                    // carry bit included
    logic [26:0]        mant_n;
    logic signed [9:0]  exp_n;
    logic               zero_n;

    // ---------------- ALIGN: unpack, classify, swap, shift ----------------
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge_b;
    logic [7:0]  ea, eb, e_big, e_small, e_diff;
    logic [22:0] fa, fb;
    logic [26:0] big_ext, small_ext, shift_mask, al_small;
    logic        al_sp;
    logic [31:0] al_sp_result;
    logic [2:0]  al_sp_flags;

    always_comb begin
        ea      = opa[30:23];
        eb      = opb[30:23];
        fa      = opa[22:0];
        fb      = opb[22:0];
        a_nan   = (ea == 8'hff) && (fa != 23'd0);
        b_nan   = (eb == 8'hff) && (fb != 23'd0);
        a_inf   = (ea == 8'hff) && (fa == 23'd0);
        b_inf   = (eb == 8'hff) && (fb == 23'd0);
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        // Exponent-then-fraction ordering makes the raw magnitude compare valid.
        a_ge_b  = (opa[30:0] >= opb[30:0]);
        e_big   = a_ge_b ? ea : eb;
        e_small = a_ge_b ? eb : ea;
        e_diff  = e_big - e_small;
        big_ext   = {1'b1, (a_ge_b ? fa : fb), 3'b000};
        small_ext = {1'b1, (a_ge_b ? fb : fa), 3'b000};
        // Shifts of 27 or more leave only the sticky bit of a nonzero mantissa.
        shift_mask = 27'd0;
        al_small   = 27'd1;
        if (e_diff < 8'd27) begin
            shift_mask = (27'd1 << e_diff) - 27'd1;
            al_small   = (small_ext >> e_diff) | {26'd0, |(small_ext & shift_mask)};
        end

        al_sp        = 1'b1;
        al_sp_result = 32'd0;
        al_sp_flags  = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (opa[31] != opb[31]))) begin
            al_sp_result = 32'h7FC00000;
            al_sp_flags  = 3'b100;
        end else if (a_inf) begin
            al_sp_result = {opa[31], 8'hff, 23'd0};
        end else if (b_inf) begin
            al_sp_result = {opb[31], 8'hff, 23'd0};
        end else if (a_zero && b_zero) begin
            al_sp_result = {opa[31] & opb[31], 31'd0};
        end else if (a_zero) begin
            al_sp_result = opb;
        end else if (b_zero) begin
            al_sp_result = opa;
        end else begin
            al_sp = 1'b0;
        end
    end

    // ---------------- NORM: carry shift or leading-zero shift ----------------
    logic [4:0]        lzc;
    logic [26:0]       nm_mant;
    logic signed [9:0] nm_exp;

    always_comb begin
        // Last hit wins while scanning upward, so lzc reflects the top set bit.
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lzc = 5'(26 - i);
        end
        if (sum[27]) begin
            // Bit shifted out on the right folds into sticky.
            nm_mant = {sum[27:2], sum[1] | sum[0]};
            nm_exp  = $signed({2'b00, exp_big}) + 10'sd1;
        end else begin
            nm_mant = sum[26:0] << lzc;
            nm_exp  = $signed({2'b00, exp_big}) - $signed({5'd0, lzc});
        end
    end

    // ---------------- ROUND: nearest-even, pack, range checks ----------------
    logic              rd_up;
    logic [24:0]       rd_sum;
    logic [22:0]       rd_frac;
    logic signed [9:0] rd_exp;
    logic [31:0]       rd_result;
    logic [2:0]        rd_flags;

    always_comb begin
        rd_up  = mant_n[2] && (mant_n[1] || mant_n[0] || mant_n[3]);
        rd_sum = {1'b0, mant_n[26:3]} + {24'd0, rd_up};
        if (rd_sum[24]) begin
            rd_frac = rd_sum[23:1];
            rd_exp  = exp_n + 10'sd1;
        end else begin
            rd_frac = rd_sum[22:0];
            rd_exp  = exp_n;
        end
        rd_flags = 3'b000;
        if (sp) begin
            rd_result = sp_result;
            rd_flags  = sp_flags;
        end else if (zero_n) begin
            rd_result = 32'd0;                  // exact cancellation gives +0
        end else if (rd_exp >= 10'sd255) begin
            rd_result = {sign_big, 8'hff, 23'd0};
            rd_flags  = 3'b010;
        end else if (rd_exp <= 10'sd0) begin
            rd_result = {sign_big, 31'd0};
            rd_flags  = 3'b001;
        end else begin
            rd_result = {sign_big, rd_exp[7:0], rd_frac};
        end
    end

    // ---------------- FSM and stage registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            result     <= 32'd0;
            flags      <= 3'b000;
            opa        <= 32'd0;
            opb        <= 32'd0;
            sp         <= 1'b0;
            sp_result  <= 32'd0;
            sp_flags   <= 3'b000;
            sign_big   <= 1'b0;
            eff_sub    <= 1'b0;
            exp_big    <= 8'd0;
            mant_big   <= 27'd0;
            mant_small <= 27'd0;
            sum        <= 28'd0;
            mant_n     <= 27'd0;
            exp_n      <= 10'sd0;
            zero_n     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready comes up one cycle after reset release.
                    if (in_valid && in_ready) begin
                        opa      <= float1;
                        opb      <= {float2[31] ^ op, float2[30:0]};
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ALIGN: begin
                    sp         <= al_sp;
                    sp_result  <= al_sp_result;
                    sp_flags   <= al_sp_flags;
                    sign_big   <= a_ge_b ? opa[31] : opb[31];
                    eff_sub    <= opa[31] ^ opb[31];
                    exp_big    <= e_big;
                    mant_big   <= big_ext;
                    mant_small <= al_small;
                    state      <= ADDSUB;
                end
                ADDSUB: begin
                    sum   <= eff_sub ? ({1'b0, mant_big} - {1'b0, mant_small})
                                     : ({1'b0, mant_big} + {1'b0, mant_small});
                    state <= NORM;
                end
                NORM: begin
                    mant_n <= nm_mant;
                    exp_n  <= nm_exp;
                    zero_n <= (sum == 28'd0);
                    state  <= ROUND;
                end
                ROUND: begin
                    result    <= rd_result;
                    flags     <= rd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
